cus19_store_buffer: RTL and testbench

//   Parametrised posted-store buffer for the IE-stage M-type ST path (ST addr, r1).

---
 rtl/cus19_store_buffer_if.sv | 36 +++
 rtl/cus19_store_buffer.sv | 86 ++++++++
 tb/tb_cus19_store_buffer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cus19_store_buffer_if.sv
// Store-buffer bus bundle: IE store handshake, DM write handshake, status and load-forward lookup.
// The master side is the IE/DM environment, the slave side is the buffer itself.
interface cus19_store_buffer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid_in;
    logic [ADDR_W-1:0] st_addr_in;
    logic [DATA_W-1:0] st_data_in;
    logic              st_ready_out;
    logic [ADDR_W-1:0] dm_wr_addr_out;
    logic [DATA_W-1:0] dm_wr_data_out;
    logic              dm_write_req;
    logic              dm_write_ack;
    logic [CNT_W-1:0]  count_out;
    logic              full_out;
    logic              empty_out;
    logic [ADDR_W-1:0] ld_addr_in;
    logic              fwd_hit_out;
    logic [DATA_W-1:0] fwd_data_out;

    modport master (
        output st_valid_in, st_addr_in, st_data_in, dm_write_ack, ld_addr_in,
        input  st_ready_out, dm_wr_addr_out, dm_wr_data_out, dm_write_req,
               count_out, full_out, empty_out, fwd_hit_out, fwd_data_out
    );

    modport slave (
        input  st_valid_in, st_addr_in, st_data_in, dm_write_ack, ld_addr_in,
        output st_ready_out, dm_wr_addr_out, dm_wr_data_out, dm_write_req,
               count_out, full_out, empty_out, fwd_hit_out, fwd_data_out
    );
endinterface

// File: rtl/cus19_store_buffer.sv
// Posted-store FIFO between IE and Data Memory; stores drain in order over a req/ack handshake.
// Define STORE_FWD_EN to add a youngest-match store-to-load forwarding lookup.
module cus19_store_buffer #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input logic              clk,
    input logic              rst,
    cus19_store_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              enq;
    logic              deq;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign enq   = sb.st_valid_in && !full;
    assign deq   = sb.dm_write_ack && !empty;

    // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq && !deq)
                count <= count + CNT_W'(1);
            else if (deq && !enq)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr] <= sb.st_addr_in;
            data_mem[wr_ptr] <= sb.st_data_in;
        end
    end

    assign sb.st_ready_out   = !full;
    assign sb.dm_write_req   = !empty;
    assign sb.dm_wr_addr_out = empty ? '0 : addr_mem[rd_ptr];
    assign sb.dm_wr_data_out = empty ? '0 : data_mem[rd_ptr];
    assign sb.count_out      = count;
    assign sb.full_out       = full;
    assign sb.empty_out      = empty;

`ifdef STORE_FWD_EN
    logic [PTR_W-1:0]  fwd_idx;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Scan oldest to youngest so the last match found is the youngest one.
    always_comb begin
        fwd_idx  = rd_ptr;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_mem[fwd_idx] == sb.ld_addr_in)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[fwd_idx];
            end
        end
    end

    assign sb.fwd_hit_out  = fwd_hit;
    assign sb.fwd_data_out = fwd_data;
`else
    assign sb.fwd_hit_out  = 1'b0;
    assign sb.fwd_data_out = '0;
`endif
endmodule

// File: tb/tb_cus19_store_buffer.sv
// Self-checking bench for cus19_store_buffer: directed scenarios plus random traffic against a queue model.
module tb_cus19_store_buffer;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    entry_t            model_q[$];
    logic [ADDR_W-1:0] dut_log[$];
    logic [ADDR_W-1:0] sent[$];

    cus19_store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) sb ();

    cus19_store_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs derived from the model queue contents alone.
    task automatic checkOutput();
        int            n;
        logic          exp_hit;
        logic [DATA_W-1:0] exp_fwd;
        n       = model_q.size();
        exp_hit = 1'b0;
        exp_fwd = '0;
`ifdef STORE_FWD_EN
        for (int i = n - 1; i >= 0; i--) begin
            if (!exp_hit && model_q[i].addr == sb.ld_addr_in) begin
                exp_hit = 1'b1;
                exp_fwd = model_q[i].data;
            end
        end
`endif
        check("st_ready", 32'(sb.st_ready_out), 32'(n < DEPTH));
        check("dm_req", 32'(sb.dm_write_req), 32'(n > 0));
        check("dm_addr", 32'(sb.dm_wr_addr_out), (n > 0) ? 32'(model_q[0].addr) : 32'd0);
        check("dm_data", 32'(sb.dm_wr_data_out), (n > 0) ? 32'(model_q[0].data) : 32'd0);
        check("count", 32'(sb.count_out), 32'(n));
        check("full", 32'(sb.full_out), 32'(n == DEPTH));
        check("empty", 32'(sb.empty_out), 32'(n == 0));
        check("fwd_hit", 32'(sb.fwd_hit_out), 32'(exp_hit));
        check("fwd_data", 32'(sb.fwd_data_out), 32'(exp_fwd));
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model at the posedge.
    task automatic applyStimulus(input logic valid, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input logic ack,
                                 input logic [ADDR_W-1:0] ld);
        logic do_enq;
        logic do_deq;
        entry_t e;
        @(negedge clk);
        sb.st_valid_in  = valid;
        sb.st_addr_in   = addr;
        sb.st_data_in   = data;
        sb.dm_write_ack = ack;
        sb.ld_addr_in   = ld;
        #1;
        checkOutput();
        if (sb.dm_write_req && ack) dut_log.push_back(sb.dm_wr_addr_out);
        do_enq = valid && (model_q.size() < DEPTH);
        do_deq = ack && (model_q.size() > 0);
        @(posedge clk);
        if (do_deq) void'(model_q.pop_front());
        if (do_enq) begin
            e.addr = addr;
            e.data = data;
            model_q.push_back(e);
        end
    endtask

    task automatic idle(input logic ack);
        applyStimulus(1'b0, '0, '0, ack, '0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst             = 1'b1;
        sb.st_valid_in  = 1'b0;
        sb.st_addr_in   = '0;
        sb.st_data_in   = '0;
        sb.dm_write_ack = 1'b0;
        sb.ld_addr_in   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state and idle
        idle(1'b0);
        #1;
        check("rst_empty", 32'(sb.empty_out), 32'd1);
        check("rst_ready", 32'(sb.st_ready_out), 32'd1);
        check("rst_req", 32'(sb.dm_write_req), 32'd0);
        check("rst_addr", 32'(sb.dm_wr_addr_out), 32'd0);
        check("rst_count", 32'(sb.count_out), 32'd0);

        // Single store, held then acknowledged
        applyStimulus(1'b1, 11'h123, 8'hA5, 1'b0, '0);
        #1;
        check("t2_req", 32'(sb.dm_write_req), 32'd1);
        check("t2_addr", 32'(sb.dm_wr_addr_out), 32'h123);
        check("t2_data", 32'(sb.dm_wr_data_out), 32'hA5);
        idle(1'b1);
        #1;
        check("t2_empty", 32'(sb.empty_out), 32'd1);

        // Fill, drop a store while full, then drain in order
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 11'h010 + 11'(i), 8'(8'h11 * (i + 1)), 1'b0, '0);
        #1;
        check("t3_full", 32'(sb.full_out), 32'd1);
        check("t3_ready", 32'(sb.st_ready_out), 32'd0);
        applyStimulus(1'b1, 11'h7FF, 8'h99, 1'b0, '0);
        #1;
        check("t3_count_after_drop", 32'(sb.count_out), 32'd4);
        dut_log.delete();
        repeat (6) idle(1'b1);
        check("t3_nwrites", 32'(dut_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < dut_log.size())
                check("t3_order", 32'(dut_log[i]), 32'h010 + 32'(i));

        // Two entries held, then simultaneous enqueue+dequeue across pointer wrap
        dut_log.delete();
        sent.delete();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 11'h100 + 11'(i), 8'(i), 1'b0, '0);
            sent.push_back(11'h100 + 11'(i));
        end
        for (int i = 2; i < 12; i++) begin
            applyStimulus(1'b1, 11'h100 + 11'(i), 8'(i), 1'b1, '0);
            sent.push_back(11'h100 + 11'(i));
            #1;
            check("t4_count", 32'(sb.count_out), 32'd2);
        end
        repeat (3) idle(1'b1);
        check("t4_nwrites", 32'(dut_log.size()), 32'(sent.size()));
        for (int i = 0; i < sent.size(); i++)
            if (i < dut_log.size())
                check("t4_order", 32'(dut_log[i]), 32'(sent[i]));

`ifdef STORE_FWD_EN
        // Forwarding picks the youngest matching store
        applyStimulus(1'b1, 11'h050, 8'h01, 1'b0, '0);
        applyStimulus(1'b1, 11'h050, 8'h02, 1'b0, '0);
        sb.st_valid_in = 1'b0;
        sb.ld_addr_in  = 11'h050;
        #1;
        check("t6_hit", 32'(sb.fwd_hit_out), 32'd1);
        check("t6_data", 32'(sb.fwd_data_out), 32'h02);
        sb.ld_addr_in = 11'h051;
        #1;
        check("t6_miss", 32'(sb.fwd_hit_out), 32'd0);
        repeat (3) idle(1'b1);
`endif

        // Asynchronous reset with stores pending
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 11'h200 + 11'(i), 8'hC0 + 8'(i), 1'b0, '0);
        @(negedge clk);
        sb.st_valid_in  = 1'b0;
        sb.dm_write_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t5_req_async", 32'(sb.dm_write_req), 32'd0);
        check("t5_count_async", 32'(sb.count_out), 32'd0);
        model_q.delete();
        @(negedge clk);
        rst = 1'b0;
        dut_log.delete();
        repeat (3) idle(1'b1);
        check("t5_no_stale", 32'(dut_log.size()), 32'd0);

        // Random traffic with a narrow address space so forwarding hits often
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 11'($urandom_range(0, 7)),
                          8'($urandom), 1'($urandom_range(0, 2) != 0),
                          11'($urandom_range(0, 7)));
        end
        repeat (DEPTH + 1) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
